// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch path.
// Holds the fetch FSM state encoding, the instruction-memory window
// (also used by program_counter and imem), the NOP encoding and a helper
// that classifies a fetch address as legal or not.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HALTED = 2'd3
    } if_state_t;

    localparam logic [31:0] IMEM_BASE = 32'h0100_0000;
    localparam logic [31:0] IMEM_LAST = 32'h0100_07FC;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    // A fetch address is legal when word aligned and inside [base, last].
    function automatic logic fetch_addr_legal(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input logic [31:0] last);
        return (addr[1:0] == 2'b00) && (addr >= base) && (addr <= last);
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Loadable up-counter with terminal flag, used to bound the wait for
// read data after a memory grant.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   load      : clear the count to zero (has priority over inc)
//   inc       : advance the count by one
//   term      : count has reached TIMEOUT-1
module fetch_timeout_ctr #(
    parameter int  TIMEOUT = 16,
    localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic inc,
    output logic term
);

    localparam logic [CW-1:0] TERM_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign term = (count_reg == TERM_VAL);

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage sitting right after the program counter.
// Issues one outstanding read at a time over req/gnt/rvalid, captures the
// returned word into the IF/ID register and strobes pc_we so the PC moves.
// Out-of-window or misaligned addresses and a stalled memory raise a sticky
// fetch_err and halt the stage; only rstn leaves the halted state.
// Ports:
//   clk, rstn              : clock, asynchronous active-low reset
//   fetch_en, instr_addr   : permission to fetch, current PC
//   pc_halt, flush         : PC halt flag, redirect (drop held/in-flight)
//   id_ready               : decode takes instr_out this cycle
//   mem_req/addr/gnt/rvalid/rdata : instruction memory handshake
//   instr_out, pc_out, instr_valid: IF/ID register contents
//   pc_we                  : one-cycle PC advance strobe
//   fetch_err, halted      : sticky error, stage stopped
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE = instr_fetch_pkg::IMEM_BASE,
    parameter logic [31:0] IMEM_LAST = instr_fetch_pkg::IMEM_LAST,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fetch_en,
    input  logic [31:0] instr_addr,
    input  logic        pc_halt,
    input  logic        flush,
    input  logic        id_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    output logic        pc_we,
    output logic        fetch_err,
    output logic        halted
);

    if_state_t   state_reg, state_next;
    logic        mem_req_next;
    logic [31:0] mem_addr_next;
    logic [31:0] instr_out_next;
    logic [31:0] pc_out_next;
    logic        instr_valid_next;
    logic        pc_we_next;
    logic        fetch_err_next;
    logic        halted_next;
    logic        discard_reg, discard_next;
    // Remembers a pc_halt seen mid-transaction so a brief pulse still halts.
    logic        halt_pend_reg, halt_pend_next;
    logic        ctr_load, ctr_inc, ctr_term;
    logic        launch;

    fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk  (clk),
        .rstn (rstn),
        .load (ctr_load),
        .inc  (ctr_inc),
        .term (ctr_term)
    );

    // pc_we blocks launch so the advanced PC is sampled before the next fetch.
    assign launch = fetch_en && !pc_we && (!instr_valid || id_ready) && !flush;

    always_comb begin
        state_next       = state_reg;
        mem_req_next     = mem_req;
        mem_addr_next    = mem_addr;
        instr_out_next   = instr_out;
        pc_out_next      = pc_out;
        instr_valid_next = instr_valid;
        pc_we_next       = 1'b0;
        fetch_err_next   = fetch_err;
        halted_next      = halted;
        discard_next     = discard_reg;
        halt_pend_next   = halt_pend_reg;
        ctr_load         = 1'b0;
        ctr_inc          = 1'b0;

        if (instr_valid && id_ready) begin
            instr_valid_next = 1'b0;
        end

        unique case (state_reg)
            ST_IDLE: begin
                if (pc_halt || halt_pend_reg) begin
                    halted_next = 1'b1;
                    state_next  = ST_HALTED;
                end else if (launch) begin
                    if (!fetch_addr_legal(instr_addr, IMEM_BASE, IMEM_LAST)) begin
                        fetch_err_next = 1'b1;
                        halted_next    = 1'b1;
                        state_next     = ST_HALTED;
                    end else begin
                        mem_req_next  = 1'b1;
                        mem_addr_next = instr_addr;
                        state_next    = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (pc_halt) halt_pend_next = 1'b1;
                if (flush)   discard_next   = 1'b1;
                if (mem_gnt) begin
                    mem_req_next = 1'b0;
                    ctr_load     = 1'b1;
                    state_next   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (pc_halt) halt_pend_next = 1'b1;
                if (mem_rvalid) begin
                    // A flush arriving with the data drops it just like a
                    // flush seen earlier in the transaction.
                    if (!discard_reg && !flush) begin
                        instr_out_next   = mem_rdata;
                        pc_out_next      = mem_addr;
                        instr_valid_next = 1'b1;
                        pc_we_next       = 1'b1;
                    end
                    discard_next = 1'b0;
                    state_next   = ST_IDLE;
                end else if (ctr_term) begin
                    fetch_err_next = 1'b1;
                    halted_next    = 1'b1;
                    discard_next   = 1'b0;
                    state_next     = ST_HALTED;
                end else begin
                    if (flush) discard_next = 1'b1;
                    ctr_inc = 1'b1;
                end
            end
            ST_HALTED: begin
                halted_next  = 1'b1;
                mem_req_next = 1'b0;
            end
            default: state_next = ST_IDLE;
        endcase

        if (flush) begin
            instr_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            instr_out     <= '0;
            pc_out        <= '0;
            instr_valid   <= 1'b0;
            pc_we         <= 1'b0;
            fetch_err     <= 1'b0;
            halted        <= 1'b0;
            discard_reg   <= 1'b0;
            halt_pend_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mem_req       <= mem_req_next;
            mem_addr      <= mem_addr_next;
            instr_out     <= instr_out_next;
            pc_out        <= pc_out_next;
            instr_valid   <= instr_valid_next;
            pc_we         <= pc_we_next;
            fetch_err     <= fetch_err_next;
            halted        <= halted_next;
            discard_reg   <= discard_next;
            halt_pend_reg <= halt_pend_next;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a table of single-fetch vectors followed
// by hand-written sequences for backpressure, flush, timeout and halt.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        fetch_en = 1'b0;
    logic [31:0] instr_addr = '0;
    logic        pc_halt = 1'b0;
    logic        flush = 1'b0;
    logic        id_ready = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        pc_we;
    logic        fetch_err;
    logic        halted;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk        (clk),
        .rstn       (rstn),
        .fetch_en   (fetch_en),
        .instr_addr (instr_addr),
        .pc_halt    (pc_halt),
        .flush      (flush),
        .id_ready   (id_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .instr_out  (instr_out),
        .pc_out     (pc_out),
        .instr_valid(instr_valid),
        .pc_we      (pc_we),
        .fetch_err  (fetch_err),
        .halted     (halted)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk1 ({tag, " mem_req"},     mem_req,     1'b0);
        chk32({tag, " mem_addr"},    mem_addr,    32'h0);
        chk32({tag, " instr_out"},   instr_out,   32'h0);
        chk32({tag, " pc_out"},      pc_out,      32'h0);
        chk1 ({tag, " instr_valid"}, instr_valid, 1'b0);
        chk1 ({tag, " pc_we"},       pc_we,       1'b0);
        chk1 ({tag, " fetch_err"},   fetch_err,   1'b0);
        chk1 ({tag, " halted"},      halted,      1'b0);
    endtask

    task automatic do_reset;
        fetch_en = 0; pc_halt = 0; flush = 0; id_ready = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        rstn = 0;
        #2;
        step;
        rstn = 1;
    endtask

    // Launch at instr_addr and give an immediate grant; leaves DUT in WAIT.
    task automatic launch_and_grant(input logic [31:0] addr);
        instr_addr = addr;
        fetch_en   = 1;
        step;
        fetch_en   = 0;
        mem_gnt    = 1;
        step;
        mem_gnt    = 0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic seen_req;
        do_reset();
        instr_addr = v.addr;
        fetch_en   = 1;
        step;
        if (v.exp_err) begin
            chk1("vec err flag", fetch_err, 1'b1);
            chk1("vec err halted", halted, 1'b1);
            seen_req = mem_req;
            repeat (3) begin
                step;
                seen_req |= mem_req;
            end
            chk1("vec err no req", seen_req, 1'b0);
            fetch_en = 0;
        end else begin
            chk1("vec req", mem_req, 1'b1);
            chk32("vec mem_addr", mem_addr, v.addr);
            fetch_en = 0;
            repeat (v.gnt_dly) step;
            chk1("vec req held", mem_req, 1'b1);
            mem_gnt = 1;
            step;
            mem_gnt = 0;
            chk1("vec req dropped", mem_req, 1'b0);
            repeat (v.rv_dly) step;
            chk1("vec not yet valid", instr_valid, 1'b0);
            mem_rvalid = 1;
            mem_rdata  = v.rdata;
            step;
            mem_rvalid = 0;
            chk1("vec valid", instr_valid, 1'b1);
            chk32("vec instr_out", instr_out, v.rdata);
            chk32("vec pc_out", pc_out, v.addr);
            chk1("vec pc_we", pc_we, 1'b1);
            step;
            chk1("vec pc_we pulse", pc_we, 1'b0);
            chk1("vec valid held", instr_valid, 1'b1);
        end
        $display("vec %0d addr=%h instr_out=%h err=%b halted=%b", idx, v.addr, instr_out, fetch_err, halted);
    endtask

    initial begin
        logic seen;

        vecs[0] = '{32'h0100_0000, 32'h0050_0093, 0, 0, 1'b0};
        vecs[1] = '{32'h0100_07FC, 32'hDEAD_BEEF, 2, 3, 1'b0};
        vecs[2] = '{32'h0100_0800, 32'h0,         0, 0, 1'b1};
        vecs[3] = '{32'h00FF_FFFC, 32'h0,         0, 0, 1'b1};
        vecs[4] = '{32'h0100_0002, 32'h0,         0, 0, 1'b1};
        vecs[5] = '{32'h0100_0400, 32'h1234_5678, 1, 0, 1'b0};

        #2;
        chk_reset_state("reset");
        step;
        rstn = 1;

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Backpressure: vecs[5] left an undelivered instruction, id_ready=0.
        instr_addr = 32'h0100_0404;
        fetch_en   = 1;
        seen = 1'b0;
        repeat (3) begin
            step;
            seen |= mem_req;
        end
        chk1("bp no req", seen, 1'b0);
        id_ready = 1;
        step;
        chk1("bp consumed", instr_valid, 1'b0);
        chk1("bp launch", mem_req, 1'b1);
        chk32("bp addr", mem_addr, 32'h0100_0404);
        id_ready = 0;
        fetch_en = 0;
        $display("seq backpressure mem_req=%b mem_addr=%h", mem_req, mem_addr);

        // Flush in WAIT: data returned later must be dropped, no pc_we.
        do_reset();
        launch_and_grant(32'h0100_0000);
        flush = 1;
        step;
        flush = 0;
        seen = pc_we;
        step;  seen |= pc_we;
        step;  seen |= pc_we;
        mem_rvalid = 1;
        mem_rdata  = 32'h0BAD_F00D;
        step;
        mem_rvalid = 0;
        seen |= pc_we;
        chk1("flush dropped", instr_valid, 1'b0);
        step;
        seen |= pc_we;
        chk1("flush no pc_we", seen, 1'b0);
        instr_addr = 32'h0100_0008;
        fetch_en   = 1;
        step;
        chk1("flush relaunch", mem_req, 1'b1);
        chk32("flush relaunch addr", mem_addr, 32'h0100_0008);
        fetch_en = 0;
        mem_gnt  = 1;
        step;
        mem_gnt    = 0;
        mem_rvalid = 1;
        mem_rdata  = 32'h0020_0113;
        step;
        mem_rvalid = 0;
        chk1("flush next valid", instr_valid, 1'b1);
        chk32("flush next instr", instr_out, 32'h0020_0113);
        $display("seq flush instr_out=%h pc_out=%h", instr_out, pc_out);

        // Timeout: 16 WAIT cycles without rvalid.
        do_reset();
        launch_and_grant(32'h0100_0010);
        seen = 1'b0;
        repeat (15) begin
            step;
            seen |= fetch_err;
        end
        chk1("tmo early", seen, 1'b0);
        step;
        chk1("tmo err", fetch_err, 1'b1);
        chk1("tmo halted", halted, 1'b1);
        chk1("tmo no req", mem_req, 1'b0);
        rstn = 0;
        #2;
        chk_reset_state("tmo reset");
        step;
        rstn = 1;
        mem_rvalid = 1;
        mem_rdata  = 32'h1111_2222;
        step;
        mem_rvalid = 0;
        chk1("late rvalid valid", instr_valid, 1'b0);
        chk1("late rvalid pc_we", pc_we, 1'b0);
        $display("seq timeout fetch_err=%b halted=%b", fetch_err, halted);

        // Halt during WAIT: finish delivering, then stop for good.
        do_reset();
        launch_and_grant(32'h0100_0020);
        pc_halt = 1;
        step;
        mem_rvalid = 1;
        mem_rdata  = 32'h00A0_0113;
        step;
        mem_rvalid = 0;
        chk1("halt delivered", instr_valid, 1'b1);
        chk32("halt instr", instr_out, 32'h00A0_0113);
        chk1("halt pc_we", pc_we, 1'b1);
        chk1("halt not yet", halted, 1'b0);
        fetch_en = 1;
        step;
        chk1("halt halted", halted, 1'b1);
        chk1("halt pc_we pulse", pc_we, 1'b0);
        id_ready = 1;
        step;
        chk1("halt drain", instr_valid, 1'b0);
        seen = mem_req;
        repeat (3) begin
            step;
            seen |= mem_req;
        end
        chk1("halt no req", seen, 1'b0);
        chk1("halt sticky", halted, 1'b1);
        $display("seq halt halted=%b mem_req=%b", halted, mem_req);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
